// File: rtl/load_register.sv
// Width-parameterised storage register with store enable and synchronous reset.
// o always reflects the stored word; d/st only act at a rising clk edge.
module load_register #(
    parameter int                   BUS_WIDTH   = 8,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 st,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 clk,
    output logic [BUS_WIDTH-1:0] o,
    input  logic                 rst
);

    logic [BUS_WIDTH-1:0] data_reg;

    // Reset takes priority over store; with neither asserted the word holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= RESET_VALUE;
        end else if (st) begin
            data_reg <= d;
        end
    end

    assign o = data_reg;

endmodule

// File: tb/tb_load_register.sv
// Directed checks of load_register: default 8-bit instance plus a 16-bit instance
// with a non-zero reset value.
module tb_load_register;

    logic        clk;
    logic        rst;
    logic        st;
    logic [7:0]  d;
    logic [7:0]  o;
    logic        rst16;
    logic        st16;
    logic [15:0] d16;
    logic [15:0] o16;

    int passed;
    int total;

    load_register dut8 (
        .st  (st),
        .d   (d),
        .clk (clk),
        .o   (o),
        .rst (rst)
    );

    load_register #(
        .BUS_WIDTH   (16),
        .RESET_VALUE (16'hA5A5)
    ) dut16 (
        .st  (st16),
        .d   (d16),
        .clk (clk),
        .o   (o16),
        .rst (rst16)
    );

    typedef struct {
        logic       rst;
        logic       st;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic rise();
        #5 clk = 1'b1;
        #1;
    endtask

    task automatic fall();
        #4 clk = 1'b0;
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        st     = 1'b0;
        d      = 8'd0;
        rst16  = 1'b0;
        st16   = 1'b0;
        d16    = 16'd0;

        vecs[0] = '{rst: 1'b0, st: 1'b1, d: 8'h55, exp: 8'h55};
        vecs[1] = '{rst: 1'b0, st: 1'b0, d: 8'hAA, exp: 8'h55};
        vecs[2] = '{rst: 1'b0, st: 1'b1, d: 8'hFF, exp: 8'hFF};
        vecs[3] = '{rst: 1'b1, st: 1'b1, d: 8'h12, exp: 8'h00};
        vecs[4] = '{rst: 1'b0, st: 1'b0, d: 8'h34, exp: 8'h00};
        vecs[5] = '{rst: 1'b0, st: 1'b1, d: 8'h80, exp: 8'h80};
        vecs[6] = '{rst: 1'b1, st: 1'b0, d: 8'h7F, exp: 8'h00};
        vecs[7] = '{rst: 1'b0, st: 1'b1, d: 8'h01, exp: 8'h01};
        vecs[8] = '{rst: 1'b0, st: 1'b1, d: 8'h00, exp: 8'h00};

        // Load after reset
        rst = 1'b1;
        rise();
        check("reset_to_zero", {8'h00, o}, 16'h0000);
        fall();
        rst = 1'b0;
        st  = 1'b1;
        d   = 8'd1;
        rise();
        check("load_after_reset", {8'h00, o}, 16'h0001);

        // No load without an edge: clk held high
        d = 8'd30;
        #2;
        check("no_load_clk_high", {8'h00, o}, 16'h0001);

        // Falling edge ignored
        d = 8'd31;
        fall();
        check("falling_edge_ignored", {8'h00, o}, 16'h0001);

        // Hold with store off, through a full cycle
        st = 1'b0;
        d  = 8'd32;
        #2;
        check("hold_clk_low", {8'h00, o}, 16'h0001);
        rise();
        check("hold_rise", {8'h00, o}, 16'h0001);
        fall();
        check("hold_fall", {8'h00, o}, 16'h0001);

        // Load new value
        st = 1'b1;
        d  = 8'd33;
        rise();
        check("load_33", {8'h00, o}, 16'd33);
        fall();

        // Table-driven edge vectors
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst;
            st  = vecs[i].st;
            d   = vecs[i].d;
            rise();
            check($sformatf("vec%0d", i), {8'h00, o}, {8'h00, vecs[i].exp});
            fall();
        end
        rst = 1'b0;
        st  = 1'b0;

        // Reset priority and width on the 16-bit instance
        rst16 = 1'b1;
        st16  = 1'b1;
        d16   = 16'hFFFF;
        rise();
        check("w16_reset_priority", o16, 16'hA5A5);
        fall();
        rst16 = 1'b0;
        d16   = 16'h1234;
        rise();
        check("w16_load", o16, 16'h1234);
        fall();
        st16 = 1'b0;
        d16  = 16'h0F0F;
        rise();
        check("w16_hold", o16, 16'h1234);
        fall();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_register.md
# load_register

Parameterised-width storage register with a store enable, used as the basic data-holding element on the memory/datapath buses. On a rising clock edge with store asserted it captures the input bus; otherwise it holds its contents. A synchronous active-high reset clears it to a parameterised value.

## Interface

- BUS_WIDTH, default 8: width of the data input and output buses, in bits (≥1).
- RESET_VALUE, default 0: value loaded into the register by reset, BUS_WIDTH bits wide.

- clk  input  1  clock; all state changes on the rising edge only.
- rst  input  1  reset, synchronous, active-high.
- st  input  1  store enable, active-high, sampled on the rising edge of clk.
- d  input  BUS_WIDTH  data to store.
- o  output  BUS_WIDTH  current register contents, driven continuously.
- Positional port order: st, d, clk, o, rst. Existing positional 4-port instances therefore stay valid. Such instances tie rst to 0.

## Operation

- There is one internal register of BUS_WIDTH bits, and o is driven directly from it. There is no combinational path from d or st to o.
- At each rising edge of clk, priority is:
  - rst=1: register becomes RESET_VALUE, regardless of st and d.
  - rst=0, st=1: register becomes d.
  - rst=0, st=0: register holds its value.
- The register does not change outside a rising clk edge:
  - Changes on d or st while clk is steady high or low do not affect o.
  - A level-high clk with st=1 does not make the register transparent.
- Reset value of o is RESET_VALUE (default 0), valid from the first rising edge with rst=1.
- Before any reset or store, o is undefined (X in simulation). This is acceptable when rst is tied low and a store precedes the first use.
- No overflow or width conversion: d and o are the same width and are copied bit-for-bit.

## Timing

- Latency is 1 clock edge. d sampled at rising edge N appears on o after edge N. o is then stable until the next qualifying edge.
- Setup and hold apply to st, d and rst relative to the rising edge of clk.
- st deasserted at an edge means no update, even if d changed.
- rst and st asserted in the same cycle: reset wins, and o = RESET_VALUE.
- Reset applied mid-operation clears the stored value at that edge. Store resumes from the next edge with rst=0 and st=1.
- Falling edges of clk have no effect.

## Test plan

- Load after reset:
  - Stimulus: rst=1 for one edge, then rst=0, st=1, d=1, clk 0→1.
  - Required: o=0 after the reset edge, o=1 after the load edge.
- No load without edge:
  - Stimulus: after o=1, hold clk=1 and change d to 30 with st=1.
  - Required: o stays 1.
- Falling edge ignored:
  - Stimulus: clk 1→0 with d=31, st=1.
  - Required: o stays 1.
- Hold when store is off:
  - Stimulus: st=0, d=32, clk low, then one full clock cycle with st=0.
  - Required: o stays 1 throughout.
- Load new value:
  - Stimulus: st=1, d=33, clk 0→1.
  - Required: o=33 after the edge.
- Reset priority and width:
  - Stimulus: BUS_WIDTH=16, RESET_VALUE=16'hA5A5. At one edge apply st=1, rst=1, d=16'hFFFF. At the next edge apply rst=0, st=1, d=16'h1234.
  - Required: o=16'hA5A5 after the first edge, o=16'h1234 after the second.
